truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/response engine for small combinational blocks: drives every input combination of an N-input, 1-output DUT, samples the DUT output and builds the measured truth table.
- Compares the measured table against an expected table latched at start and reports pass/fail plus a mismatch count.
- Sits beside a combinational circuit under characterisation, replacing a hand-written exhaustive testbench loop with synthesizable hardware (self-test).

Parameters:
- N_IN, default 3: number of DUT inputs; table depth is 2**N_IN (legal range 1..6).
- SETTLE, default 1: extra hold cycles per vector before sampling (legal range 0..15); each vector is held SETTLE+1 cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a sweep; accepted only in IDLE.
- expected  input  2**N_IN  expected table, bit i = expected output for input vector i; latched on accept.
- dut_out  input  1  output of the DUT being swept.
- dut_in  output  N_IN  vector driven to the DUT.
- busy  output  1  high from accept until the final sample.
- done  output  1  one-cycle pulse after the final sample.
- table_out  output  2**N_IN  measured table, bit i = sampled dut_out for vector i.
- mismatch_count  output  N_IN+1  number of bits where table_out differs from expected.
- pass  output  1  high when the last completed sweep had zero mismatches.

Behaviour:
- Reset (async assert, sync release): state IDLE; dut_in=0, busy=0, done=0, table_out=0, mismatch_count=0, pass=0, internal idx=0, cnt=0, exp_q=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, go to RUN. Same edge: exp_q<=expected, idx<=0, cnt<=0, table_out<=0, mismatch_count<=0, pass<=0, busy<=1.
- RUN: dut_in = idx (registered, changes only on a vector advance).
  - cnt<SETTLE: cnt++.
  - cnt==SETTLE: table_out[idx]<=dut_out; mismatch_count increments if dut_out != exp_q[idx].
  - Then, if idx==2**N_IN-1: go to DONE, busy<=0, done<=1, dut_in holds the last vector.
  - Otherwise: idx++, cnt<=0.
- DONE: held for one cycle with done=1. pass<=(final mismatch_count==0), computed including the last sample. Then IDLE; done<=0.
- Latency: done is high in the cycle after edge E0+2**N_IN*(SETTLE+1), where E0 is the accept edge (default: E0+16).
- After DONE, dut_in returns to 0 in IDLE. table_out, mismatch_count and pass hold until the next accept.
- start while busy or in DONE: ignored, no restart, no queuing. start held high continuously: a new sweep starts on the first IDLE edge after DONE.
- expected changing during RUN: no effect, because exp_q is used.
- Width: mismatch_count cannot overflow, since the maximum 2**N_IN fits in N_IN+1 bits.
- Reset mid-sweep: immediate return to reset values, partial table discarded, no done pulse.
- dut_out is assumed stable by the sample edge. SETTLE covers DUT propagation; no synchronizer is inside the block.

Decomposition:
- Shared package: state enum (IDLE, RUN, DONE), SETTLE counter width constant (4 bits), helper function for table depth (2**N_IN).
- Natural sub-module: sweep_counter (idx/cnt nested counter with terminal-count flag). Compare/accumulate logic stays in the top.

Test Plan:
- Reference DUT ((a&b&c)|(b^~c))^~a, with a=dut_in[2], b=dut_in[1], c=dut_in[0]; expected=8'h96; SETTLE=1; pulse start -> dut_in steps 0..7 every 2 cycles; done at accept+16 edges; table_out=8'h96, mismatch_count=0, pass=1.
- Same DUT, expected=8'h97 -> table_out=8'h96, mismatch_count=1, pass=0; expected=8'h69 -> mismatch_count=8, pass=0.
- SETTLE=0, DUT = AND3, expected=8'h80 -> one vector per cycle; done at accept+8 edges; table_out=8'h80, pass=1.
- Pulse start again at accept+5, and change expected to 8'h00 mid-sweep -> no restart, result still uses 8'h96, pass=1, exactly one done pulse.
- Deassert rst_n at accept+7 for 2 cycles -> all outputs 0 immediately, no done pulse; a new start then gives a full correct sweep.
- start held high for 40 cycles -> back-to-back sweeps with done pulses 17 cycles apart (SETTLE=1); busy low only in the DONE and IDLE cycles between sweeps.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, settle counter width
// and the table depth for a given input count.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned CntW = 4;

  function automatic int unsigned table_depth(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Handshake and table bus between the sweeper and whoever requests a sweep and hosts the DUT.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned Depth = truth_table_sweeper_pkg::table_depth(N_IN);

  logic             start;
  logic [Depth-1:0] expected;
  logic             dut_out;
  logic [N_IN-1:0]  dut_in;
  logic             busy;
  logic             done;
  logic [Depth-1:0] table_out;
  logic [N_IN:0]    mismatch_count;
  logic             pass;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, table_out, mismatch_count, pass
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, table_out, mismatch_count, pass
  );

endinterface

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Nested vector/settle counter: idx advances once every SETTLE+1 enabled cycles and holds at
// the final vector; sample_o marks the cycle in which the current vector is sampled.
module truth_table_sweeper_sweep_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [N_IN-1:0] idx_o,
  output logic            sample_o,
  output logic            last_o
);

  logic [N_IN-1:0] idx_d, idx_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  assign sample_o = en_i && (cnt_q == CntW'(SETTLE));
  assign last_o   = sample_o && (idx_q == {N_IN{1'b1}});
  assign idx_o    = idx_q;

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      if (sample_o) begin
        // The last vector stays on dut_in through the DONE cycle.
        if (!last_o) begin
          idx_d = idx_q + N_IN'(1);
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response engine: walks every input vector of an N_IN-input DUT, records
// the sampled output as a truth table and scores it against a table latched at start.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave sweep
);

  localparam int unsigned Depth = table_depth(N_IN);
  localparam int unsigned MisW  = N_IN + 1;

  state_e           state_d, state_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;
  logic [Depth-1:0] table_d, table_q;
  logic [Depth-1:0] exp_d, exp_q;
  logic [MisW-1:0]  mis_d, mis_q;

  logic            cnt_clr, cnt_en, sample, last;
  logic [N_IN-1:0] idx;

  truth_table_sweeper_sweep_counter #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE)
  ) u_sweep_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .idx_o   (idx),
    .sample_o(sample),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    table_d = table_q;
    exp_d   = exp_q;
    mis_d   = mis_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sweep.start) begin
          state_d = StRun;
          exp_d   = sweep.expected;
          table_d = '0;
          mis_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        cnt_en = 1'b1;
        if (sample) begin
          table_d[idx] = sweep.dut_out;
          if (sweep.dut_out != exp_q[idx]) mis_d = mis_q + MisW'(1);
          if (last) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        // mis_q already includes the final sample taken on the edge into DONE.
        pass_d  = (mis_q == '0);
        cnt_clr = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= '0;
      exp_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
    end
  end

  assign sweep.dut_in         = idx;
  assign sweep.busy           = busy_q;
  assign sweep.done           = done_q;
  assign sweep.pass           = pass_q;
  assign sweep.table_out      = table_q;
  assign sweep.mismatch_count = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: SETTLE=1 sweeper on a 3-input reference function, SETTLE=0 sweeper on AND3.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) a ();
  truth_table_sweeper_if #(.N_IN(3)) b ();

  truth_table_sweeper #(
    .N_IN  (3),
    .SETTLE(1)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .sweep(a)
  );

  truth_table_sweeper #(
    .N_IN  (3),
    .SETTLE(0)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .sweep(b)
  );

  // Reference circuit ((a&b&c)|(b xnor c)) xnor a, with a=dut_in[2] -> table 8'h96.
  assign a.dut_out = ((a.dut_in[2] & a.dut_in[1] & a.dut_in[0]) | (a.dut_in[1] ~^ a.dut_in[0]))
                     ~^ a.dut_in[2];
  assign b.dut_out = &b.dut_in;

  int n_chk  = 0;
  int n_pass = 0;
  int first_done, done_cnt, done_gap, last_done, busy_low, step_bad, rst_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Accept a sweep on sweeper A, then observe n_edges further edges (sampled 1 time unit after
  // each). start is held for edges 1..hold_k, re-pulsed with expected=0 at poke_k, and reset is
  // asserted after edge rst_k for two cycles (negative values disable those actions).
  task automatic sweep_a(input logic [7:0] exp_v, input int hold_k, input int poke_k,
                         input int rst_k, input int n_edges);
    int want;
    @(negedge clk);
    a.start    = 1'b1;
    a.expected = exp_v;
    @(posedge clk);
    #1;
    first_done = -1; last_done = -1; done_gap = -1;
    done_cnt = 0; busy_low = 0; step_bad = 0; rst_bad = 0;
    if (a.busy !== 1'b1 || a.dut_in !== 3'd0) step_bad++;
    for (int k = 1; k <= n_edges; k++) begin
      a.start = (k <= hold_k) || (k == poke_k);
      if (k == poke_k) a.expected = 8'h00;
      @(posedge clk);
      #1;
      if (a.done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        if (last_done >= 0 && done_gap < 0) done_gap = k - last_done - 1;
        last_done = k;
      end
      if (a.busy !== 1'b1) busy_low++;
      if (rst_k < 0 && k <= 16) begin
        want = (k / 2 > 7) ? 7 : k / 2;
        if (a.dut_in !== 3'(want) || a.busy !== (k < 16)) step_bad++;
      end
      if (rst_k > 0 && k == rst_k) begin
        rst_n = 1'b0;
        #1;
        if ({a.busy, a.done, a.dut_in, a.table_out, a.mismatch_count, a.pass} !== '0) rst_bad++;
      end
      if (rst_k > 0 && k == rst_k + 2) rst_n = 1'b1;
    end
    a.start = 1'b0;
  endtask

  initial begin
    a.start = 1'b0; a.expected = 8'h00;
    b.start = 1'b0; b.expected = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_dut_in", 32'(a.dut_in), 0);
    check("rst_busy", 32'(a.busy), 0);
    check("rst_done", 32'(a.done), 0);
    check("rst_table", 32'(a.table_out), 0);
    check("rst_mismatch", 32'(a.mismatch_count), 0);
    check("rst_pass", 32'(a.pass), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Matching expected table.
    sweep_a(8'h96, 0, -1, -1, 24);
    check("m_done_edge", 32'(first_done), 16);
    check("m_done_cnt", 32'(done_cnt), 1);
    check("m_steps", 32'(step_bad), 0);
    check("m_table", 32'(a.table_out), 32'h96);
    check("m_mismatch", 32'(a.mismatch_count), 0);
    check("m_pass", 32'(a.pass), 1);
    check("m_idle_dut_in", 32'(a.dut_in), 0);

    // One differing bit, then every bit differing.
    sweep_a(8'h97, 0, -1, -1, 24);
    check("x1_table", 32'(a.table_out), 32'h96);
    check("x1_mismatch", 32'(a.mismatch_count), 1);
    check("x1_pass", 32'(a.pass), 0);
    sweep_a(8'h69, 0, -1, -1, 24);
    check("x8_mismatch", 32'(a.mismatch_count), 8);
    check("x8_pass", 32'(a.pass), 0);

    // SETTLE=0 on AND3: one vector per cycle.
    @(negedge clk);
    b.start = 1'b1; b.expected = 8'h80;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    first_done = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b.done === 1'b1 && first_done < 0) first_done = k;
    end
    check("s0_done_edge", 32'(first_done), 8);
    check("s0_table", 32'(b.table_out), 32'h80);
    check("s0_pass", 32'(b.pass), 1);

    // Restart attempt and expected change mid-sweep.
    sweep_a(8'h96, 0, 5, -1, 24);
    check("re_done_cnt", 32'(done_cnt), 1);
    check("re_done_edge", 32'(first_done), 16);
    check("re_mismatch", 32'(a.mismatch_count), 0);
    check("re_pass", 32'(a.pass), 1);

    // Reset mid-sweep discards the partial table and suppresses done.
    sweep_a(8'h96, 0, -1, 7, 24);
    check("rs_outputs_zero", 32'(rst_bad), 0);
    check("rs_no_done", 32'(done_cnt), 0);
    check("rs_table_kept_zero", 32'(a.table_out), 0);
    sweep_a(8'h96, 0, -1, -1, 24);
    check("rs_resweep_done", 32'(first_done), 16);
    check("rs_resweep_table", 32'(a.table_out), 32'h96);
    check("rs_resweep_pass", 32'(a.pass), 1);

    // start held high: back-to-back sweeps.
    sweep_a(8'h96, 40, -1, -1, 40);
    check("bb_done_cnt", 32'(done_cnt), 2);
    check("bb_first_done", 32'(first_done), 16);
    check("bb_done_gap", 32'(done_gap), 17);
    check("bb_busy_low", 32'(busy_low), 4);
    repeat (24) @(posedge clk);
    #1;
    check("bb_final_pass", 32'(a.pass), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
